alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset, with the ports listed in REQ-002.
REQ-002 clk  input  1  rising-edge clock; rst  input  1  asynchronous, active-high reset.
REQ-003 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-004 reqN_ready  output  1  arbiter accepts requester N this cycle.
REQ-005 reqN_a, reqN_b  input  32 each  operands of requester N.
REQ-006 reqN_aluc  input  4  operation code of requester N, using the ALU encoding.
REQ-007 alu_a, alu_b  output  32 each  operands driven to the shared ALU.
REQ-008 alu_aluc  output  4  operation code driven to the shared ALU.
REQ-009 alu_r  input  32  ALU result.
REQ-010 alu_zero, alu_carry, alu_negative, alu_overflow  input  1 each  ALU flags.
REQ-011 rsp_valid  output  1  response register holds a result.
REQ-012 rsp_ready  input  1  consumer takes the response.
REQ-013 rsp_id  output  1  requester that issued the response.
REQ-014 rsp_r  output  32  captured result.
REQ-015 rsp_flags  output  4  captured flags {zero, carry, negative, overflow}.

Function
REQ-016 SHALL be a two-stage pipeline: issue register (iss_valid, id, a, b, aluc) feeding the ALU, then response register.
REQ-017 alu_a/alu_b/alu_aluc SHALL be driven from the issue register only; when iss_valid=0 they SHALL be 0.
REQ-018 Acceptance SHALL occur on a rising edge where reqN_valid=1 and reqN_ready=1.
REQ-019 adv = iss_valid & (~rsp_valid | rsp_ready); can_accept = ~iss_valid | adv.
REQ-020 At most one reqN_ready SHALL be high per cycle; reqN_ready = can_accept & (grant==N).
REQ-021 grant SHALL be combinational: only one requester valid -> that requester; both valid -> the one not recorded as last granted; neither -> no ready asserted.
REQ-022 The last-grant pointer SHALL update only on acceptance, to the accepted requester id.
REQ-023 reqN_ready SHALL NOT depend on rsp_ready except through adv (one combinational path, no loops).
REQ-024 On acceptance, the issue register SHALL load the granted operands and id; iss_valid=1.
REQ-025 On adv, the response register SHALL load alu_r, flags, and issue id; rsp_valid=1.
REQ-026 adv without new acceptance SHALL clear iss_valid; rsp_valid & rsp_ready without adv SHALL clear rsp_valid.
REQ-027 Latency: accept at edge N -> rsp_valid high after edge N+1 when the response slot is free.
REQ-028 Throughput SHALL be one operation per cycle while rsp_ready=1.
REQ-029 While stalled (iss_valid=1, rsp_valid=1, rsp_ready=0), issue register, ALU drive, and response outputs SHALL hold stable; both reqN_ready=0.
REQ-030 Flags SHALL be captured exactly as presented; no reinterpretation by aluc.
REQ-031 Responses SHALL leave in acceptance order; no operation dropped or duplicated.
REQ-032 A requester holding valid SHALL be accepted within 2 acceptances (starvation-free).

Reset
REQ-033 rst=1 SHALL immediately clear iss_valid, rsp_valid, rsp_id, rsp_r, rsp_flags, issue fields and alu_* to 0; reqN_ready=0 while rst=1.
REQ-034 Last-grant pointer SHALL reset to 1, so requester 0 wins the first contention.
REQ-035 Reset mid-operation SHALL discard in-flight operations without producing a response.

Verification
REQ-036 Single op: req0 a=5, b=3, aluc=0000, rsp_ready=1 -> rsp_valid one cycle after accept, rsp_r=8, rsp_id=0, rsp_flags=0000.
REQ-037 Contention: both valid continuously for 4 accepts after reset -> grant order 0,1,0,1; responses in the same order.
REQ-038 Backpressure: rsp_ready=0 with 3 ops offered -> exactly 2 accepted (iss+rsp full), both reqN_ready=0, outputs stable; release rsp_ready -> remaining op accepted, all 3 delivered in order.
REQ-039 Flags: req1 a=0x7FFFFFFF, b=1, aluc=0010 -> rsp_r=0x80000000, negative=1, overflow=1, rsp_id=1.
REQ-040 Reset mid-op: assert rst with iss_valid=1 and rsp_valid=1 -> all outputs 0 asynchronously; after release, no stale response; first contention grants requester 0.
REQ-041 Back-to-back: req0 streams 8 ops with rsp_ready=1 -> 8 responses on 8 consecutive cycles, results matching ALU model.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Two-requester round-robin front end for a shared ALU.
//               Stage 1 (issue register) drives the ALU operands, stage 2
//               (response register) captures the ALU result and flags.
//               A ready/valid handshake on both sides; the pipeline moves
//               one operation per cycle while the consumer is ready.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst                    rising-edge clock, async active-high reset
//   reqN_valid / reqN_ready     requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_aluc   requester N operands and operation code
//   alu_a, alu_b, alu_aluc      operands driven to the shared ALU
//   alu_r, alu_zero, alu_carry,
//   alu_negative, alu_overflow  ALU result and flags
//   rsp_valid / rsp_ready       response handshake
//   rsp_id, rsp_r, rsp_flags    response payload, flags {z, c, n, v}
// ============================================================================
module alu_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [3:0]  req0_aluc,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [3:0]  req1_aluc,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_aluc,
    input  logic [31:0] alu_r,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_negative,
    input  logic        alu_overflow,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [31:0] rsp_r,
    output logic [3:0]  rsp_flags
);

    // Issue stage
    logic        r_iss_valid;
    logic        r_iss_id;
    logic [31:0] r_iss_a;
    logic [31:0] r_iss_b;
    logic [3:0]  r_iss_aluc;

    // Response stage
    logic        r_rsp_valid;
    logic        r_rsp_id;
    logic [31:0] r_rsp_r;
    logic [3:0]  r_rsp_flags;

    // Requester most recently accepted; the other one wins a tie.
    logic        r_last;

    logic        w_adv;
    logic        w_can_accept;
    logic        w_any;
    logic        w_grant;
    logic        w_accept;
    logic [31:0] w_sel_a;
    logic [31:0] w_sel_b;
    logic [3:0]  w_sel_aluc;

    // The issue slot moves forward when the response slot is empty or is
    // being drained this cycle; a new op can enter whenever the issue slot
    // is empty or moving forward.
    assign w_adv        = r_iss_valid & (~r_rsp_valid | rsp_ready);
    assign w_can_accept = ~r_iss_valid | w_adv;

    // Lone requester wins outright; on a tie the one not last granted wins.
    assign w_any   = req0_valid | req1_valid;
    assign w_grant = (req0_valid & req1_valid) ? ~r_last : req1_valid;

    // Readies are masked by rst so nothing is offered while reset is held.
    assign req0_ready = ~rst & w_can_accept & w_any & ~w_grant;
    assign req1_ready = ~rst & w_can_accept & w_any &  w_grant;
    assign w_accept   = req0_ready | req1_ready;

    assign w_sel_a    = w_grant ? req1_a    : req0_a;
    assign w_sel_b    = w_grant ? req1_b    : req0_b;
    assign w_sel_aluc = w_grant ? req1_aluc : req0_aluc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_iss_valid <= 1'b0;
            r_iss_id    <= 1'b0;
            r_iss_a     <= 32'd0;
            r_iss_b     <= 32'd0;
            r_iss_aluc  <= 4'd0;
            r_last      <= 1'b1;
        end else if (w_accept) begin
            r_iss_valid <= 1'b1;
            r_iss_id    <= w_grant;
            r_iss_a     <= w_sel_a;
            r_iss_b     <= w_sel_b;
            r_iss_aluc  <= w_sel_aluc;
            r_last      <= w_grant;
        end else if (w_adv) begin
            r_iss_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= 1'b0;
            r_rsp_r     <= 32'd0;
            r_rsp_flags <= 4'd0;
        end else if (w_adv) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= r_iss_id;
            r_rsp_r     <= alu_r;
            r_rsp_flags <= {alu_zero, alu_carry, alu_negative, alu_overflow};
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    // ALU sees zeros whenever no operation is in the issue slot.
    assign alu_a    = r_iss_valid ? r_iss_a    : 32'd0;
    assign alu_b    = r_iss_valid ? r_iss_b    : 32'd0;
    assign alu_aluc = r_iss_valid ? r_iss_aluc : 4'd0;

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_rsp_id;
    assign rsp_r     = r_rsp_r;
    assign rsp_flags = r_rsp_flags;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Self-checking bench for alu_arbiter with a behavioural ALU.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [3:0]  req0_aluc, req1_aluc;
    logic [31:0] alu_a, alu_b, alu_r;
    logic [3:0]  alu_aluc;
    logic        alu_zero, alu_carry, alu_negative, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_id;
    logic [31:0] rsp_r;
    logic [3:0]  rsp_flags;

    int total  = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_aluc(req0_aluc),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_aluc(req1_aluc),
        .alu_a(alu_a), .alu_b(alu_b), .alu_aluc(alu_aluc),
        .alu_r(alu_r), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_negative(alu_negative), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_r(rsp_r), .rsp_flags(rsp_flags)
    );

    // Behavioural ALU: returns {zero, carry, negative, overflow, result}.
    // 0000/0010 add, 0001 sub (carry = borrow), 0100 and, 0101 or, 0110 xor.
    function automatic logic [35:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] op);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = 33'd0; r = 32'd0; c = 1'b0; v = 1'b0;
        case (op)
            4'b0000, 4'b0010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            4'b0001: begin
                r = a - b; c = (a < b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            4'b0100: r = a & b;
            4'b0101: r = a | b;
            4'b0110: r = a ^ b;
            default: r = 32'd0;
        endcase
        return {(r == 32'd0), c, r[31], v, r};
    endfunction

    assign {alu_zero, alu_carry, alu_negative, alu_overflow, alu_r} =
        alu_model(alu_a, alu_b, alu_aluc);

    typedef struct {
        logic        id;
        logic [31:0] r;
        logic [3:0]  f;
        int          cyc;
    } rsp_t;

    bit   acc_q[$];
    rsp_t rsp_q[$];

    // Handshakes are sampled mid-cycle, where inputs and registers are stable
    // for the coming rising edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (req0_valid && req0_ready) acc_q.push_back(1'b0);
            if (req1_valid && req1_ready) acc_q.push_back(1'b1);
            if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_t'{rsp_id, rsp_r, rsp_flags, cyc});
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passed++;
    endtask

    task automatic set_req(input bit n, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [3:0] op);
        if (n) begin
            req1_valid = v; req1_a = a; req1_b = b; req1_aluc = op;
        end else begin
            req0_valid = v; req0_a = a; req0_b = b; req0_aluc = op;
        end
    endtask

    typedef struct {
        logic        sel;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  aluc;
        logic [31:0] exp_r;
        logic [3:0]  exp_f;
    } vec_t;

    vec_t        vecs[7];
    logic [31:0] ops_a[8];
    logic [31:0] ops_b[8];
    logic [3:0]  ops_c[8];
    logic [3:0]  b2b_codes[4];
    logic [35:0] m;
    bit          got;
    int          n;

    initial begin
        // {sel, a, b, aluc, expected r, expected flags {z,c,n,v}}
        vecs[0] = '{1'b0, 32'd5,        32'd3,        4'b0000, 32'd8,        4'b0000};
        vecs[1] = '{1'b1, 32'h7FFFFFFF, 32'd1,        4'b0010, 32'h80000000, 4'b0011};
        vecs[2] = '{1'b0, 32'd5,        32'd5,        4'b0001, 32'd0,        4'b1000};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'd1,        4'b0000, 32'd0,        4'b1100};
        vecs[4] = '{1'b0, 32'hF0F0F0F0, 32'h0FF00FF0, 4'b0100, 32'h00F000F0, 4'b0000};
        vecs[5] = '{1'b1, 32'd3,        32'd5,        4'b0001, 32'hFFFFFFFE, 4'b0110};
        vecs[6] = '{1'b0, 32'hA,        32'h5,        4'b0110, 32'hF,        4'b0000};

        rst = 1'b1; rsp_ready = 1'b0;
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);

        // ---------------- reset state ----------------
        @(posedge clk); @(posedge clk); #1;
        set_req(0, 1, 32'd9, 32'd9, 4'd0);
        set_req(1, 1, 32'd9, 32'd9, 4'd0);
        #1;
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_r", rsp_r, 0);
        chk("rst_rsp_flags", rsp_flags, 0);
        chk("rst_rsp_id", rsp_id, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_aluc", alu_aluc, 0);
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- single-op vectors ----------------
        rsp_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            set_req(vecs[i].sel, 1, vecs[i].a, vecs[i].b, vecs[i].aluc);
            got = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (vecs[i].sel ? req1_ready : req0_ready) begin
                    got = 1;
                    break;
                end
            end
            chk($sformatf("v%0d_accept", i), got, 1);
            @(posedge clk); #1;
            set_req(vecs[i].sel, 0, 0, 0, 0);
            chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].a);
            chk($sformatf("v%0d_alu_aluc", i), alu_aluc, vecs[i].aluc);
            chk($sformatf("v%0d_rsp_early", i), rsp_valid, 0);
            @(posedge clk); #1;
            chk($sformatf("v%0d_rsp_valid", i), rsp_valid, 1);
            chk($sformatf("v%0d_rsp_id", i), rsp_id, vecs[i].sel);
            chk($sformatf("v%0d_rsp_r", i), rsp_r, vecs[i].exp_r);
            chk($sformatf("v%0d_rsp_flags", i), rsp_flags, vecs[i].exp_f);
            @(posedge clk); #1;
        end
        chk("idle_alu_a", alu_a, 0);
        chk("idle_rsp_valid", rsp_valid, 0);

        // ---------------- backpressure ----------------
        acc_q.delete(); rsp_q.delete();
        rsp_ready = 1'b0;
        ops_a[0] = 32'd10; ops_a[1] = 32'd20; ops_a[2] = 32'd30;
        ops_b[0] = 32'd1;  ops_b[1] = 32'd2;  ops_b[2] = 32'd3;
        for (int k = 0; k < 8; k++) begin
            n = acc_q.size();
            if (n < 3) set_req(0, 1, ops_a[n], ops_b[n], 4'b0000);
            else       set_req(0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        chk("bp_accepted", acc_q.size(), 2);
        chk("bp_req0_ready", req0_ready, 0);
        chk("bp_req1_ready", req1_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        chk("bp_rsp_r", rsp_r, 32'd11);
        chk("bp_alu_a", alu_a, 32'd20);
        repeat (3) begin @(posedge clk); #1; end
        chk("bp_hold_rsp_r", rsp_r, 32'd11);
        chk("bp_hold_alu_a", alu_a, 32'd20);
        chk("bp_hold_accepted", acc_q.size(), 2);
        rsp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            n = acc_q.size();
            if (n < 3) set_req(0, 1, ops_a[n], ops_b[n], 4'b0000);
            else       set_req(0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        chk("bp_total_accepted", acc_q.size(), 3);
        chk("bp_rsp_count", rsp_q.size(), 3);
        for (int i = 0; i < 3; i++)
            if (i < rsp_q.size())
                chk($sformatf("bp_rsp%0d_r", i), rsp_q[i].r, 11 * (i + 1));

        // ---------------- reset mid-operation ----------------
        acc_q.delete(); rsp_q.delete();
        rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            n = acc_q.size();
            if (n < 2) set_req(0, 1, 32'd1 + n, 32'd1, 4'b0000);
            else       set_req(0, 1, 32'd7, 32'd7, 4'b0000);
            @(posedge clk); #1;
        end
        chk("mid_pre_rsp_valid", rsp_valid, 1);
        chk("mid_pre_alu_a", alu_a, 32'd2);
        #2 rst = 1'b1;
        #1;
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_rsp_r", rsp_r, 0);
        chk("mid_rsp_flags", rsp_flags, 0);
        chk("mid_alu_a", alu_a, 0);
        chk("mid_req0_ready", req0_ready, 0);
        @(posedge clk); @(posedge clk); #1;
        set_req(0, 0, 0, 0, 0);
        rst = 1'b0; rsp_ready = 1'b1;
        acc_q.delete(); rsp_q.delete();
        repeat (3) begin @(posedge clk); #1; end
        chk("mid_no_stale_rsp", rsp_q.size(), 0);
        chk("mid_after_rsp_valid", rsp_valid, 0);

        // ---------------- contention ----------------
        acc_q.delete(); rsp_q.delete();
        set_req(0, 1, 32'd100, 32'd1, 4'b0000);
        set_req(1, 1, 32'd200, 32'd2, 4'b0001);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (acc_q.size() >= 4) break;
        end
        set_req(0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0);
        repeat (4) begin @(posedge clk); #1; end
        chk("cont_accepted", acc_q.size(), 4);
        chk("cont_rsp_count", rsp_q.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < acc_q.size()) chk($sformatf("cont_grant%0d", i), acc_q[i], i % 2);
            if (i < rsp_q.size()) begin
                chk($sformatf("cont_rsp%0d_id", i), rsp_q[i].id, i % 2);
                chk($sformatf("cont_rsp%0d_r", i), rsp_q[i].r, (i % 2) ? 32'd198 : 32'd101);
            end
        end

        // ---------------- back-to-back stream ----------------
        acc_q.delete(); rsp_q.delete();
        b2b_codes[0] = 4'b0000; b2b_codes[1] = 4'b0001;
        b2b_codes[2] = 4'b0101; b2b_codes[3] = 4'b0110;
        for (int i = 0; i < 8; i++) begin
            ops_a[i] = 32'(i * 7 + 1);
            ops_b[i] = 32'(i + 2);
            ops_c[i] = b2b_codes[i % 4];
        end
        for (int k = 0; k < 20; k++) begin
            n = acc_q.size();
            if (n < 8) set_req(0, 1, ops_a[n], ops_b[n], ops_c[n]);
            else       set_req(0, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        chk("b2b_rsp_count", rsp_q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < rsp_q.size()) begin
                m = alu_model(ops_a[i], ops_b[i], ops_c[i]);
                chk($sformatf("b2b%0d_r", i), rsp_q[i].r, m[31:0]);
                chk($sformatf("b2b%0d_flags", i), rsp_q[i].f, m[35:32]);
                chk($sformatf("b2b%0d_cycle", i), rsp_q[i].cyc - rsp_q[0].cyc, i);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
